// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the instruction fetch unit.
package fetch_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two circular buffer with synchronous flush.
// Push into a full queue is accepted only when a pop frees a slot in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch unit with redirect/drain handling.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned redirect raises a fault and halts fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int             DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  output logic              fault_valid,
  output logic [XLEN-1:0]   fault_addr
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int QW = XLEN + INST_W;

  state_e          state;
  state_e          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nxt;
  logic [CW-1:0]   q_count;
  logic [QW-1:0]   q_head;
  logic            q_empty;
  logic            accept;
  logic            push;
  logic            flush;
  logic [XLEN-1:0] rsp_pc;

  assign imem_req_addr  = pc;
  assign imem_req_valid = !reset && (state == RUN) &&
                          (({1'b0, inflight} + {1'b0, q_count}) < SW'(DEPTH));
  assign accept         = imem_req_valid && imem_req_ready;
  // In RUN nothing outstanding is being dropped, so the oldest response belongs to pc - 4*inflight.
  assign rsp_pc         = pc - (XLEN'(inflight) * XLEN'(INST_BYTES));

  assign inst_valid = !q_empty;
  assign inst_pc    = q_head[QW-1:INST_W];
  assign inst_data  = q_head[INST_W-1:0];

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_set;
`endif

  // Next-state, PC, credit and drop accounting.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drop_nxt     = drop_cnt;
    push         = 1'b0;
    flush        = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    fault_set    = 1'b0;
`endif
    inflight_nxt = inflight + CW'(accept) - CW'(imem_rsp_valid);
    if (accept) begin
      pc_nxt = pc + XLEN'(INST_BYTES);
    end else begin
      pc_nxt = pc;
    end
    case (state)
      RUN:   push = imem_rsp_valid;
      DRAIN: begin
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_nxt = drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) begin
            state_nxt = RUN;
          end else begin
            state_nxt = DRAIN;
          end
        end else begin
          drop_nxt = drop_cnt;
        end
      end
      HALT:    push = 1'b0;
      default: state_nxt = RUN;
    endcase
    // Redirect overrides everything above: the accepted request and any same-cycle response are dropped.
    if (redirect_valid && (state != HALT)) begin
      flush = 1'b1;
      push  = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_target[1:0] != 2'b00) begin
        fault_set = 1'b1;
        pc_nxt    = redirect_target;
        drop_nxt  = '0;
        state_nxt = HALT;
      end else begin
        pc_nxt    = redirect_target;
        drop_nxt  = inflight_nxt;
        state_nxt = (inflight_nxt != '0) ? DRAIN : RUN;
      end
`else
      pc_nxt    = redirect_target & ~XLEN'(2'b11);
      drop_nxt  = inflight_nxt;
      state_nxt = (inflight_nxt != '0) ? DRAIN : RUN;
`endif
    end else begin
      flush = 1'b0;
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_VEC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Sticky fault record, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
    end else if (fault_set) begin
      fault_valid <= 1'b1;
      fault_addr  <= redirect_target;
    end else begin
      fault_valid <= fault_valid;
      fault_addr  <= fault_addr;
    end
  end
`else
  assign fault_valid = 1'b0;
  assign fault_addr  = '0;
`endif

  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (inst_valid && inst_ready),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with an in-order latency memory model.
module tb_fetch_unit;
  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault_valid;
  logic [31:0] fault_addr;

  fetch_unit #(.XLEN(32), .RESET_VEC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fault_valid(fault_valid), .fault_addr(fault_addr)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc;
  int    lat;
  int    n_vec;
  int    n_bad;
  int    fl;

  typedef struct {
    string       name;
    logic        rst, ir, rdy, redir;
    logic [31:0] tgt;
    int          lat;
    logic        full, e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic        e_fv;
    logic [31:0] e_fa;
  } vec_t;
  vec_t vt[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  function automatic void add_x(input string nm, input logic ir, input logic rdy, input logic redir,
                                input logic [31:0] tgt, input logic erv, input logic [31:0] ea,
                                input logic eiv, input logic [31:0] epc, input logic efv, input logic [31:0] efa);
    vec_t v;
    v.name = nm; v.rst = 1'b0; v.ir = ir; v.rdy = rdy; v.redir = redir; v.tgt = tgt; v.lat = fl;
    v.full = 1'b1; v.e_rv = erv; v.e_addr = ea; v.e_iv = eiv; v.e_pc = epc; v.e_fv = efv; v.e_fa = efa;
    vt.push_back(v);
  endfunction

  function automatic void add(input string nm, input logic ir, input logic rdy, input logic redir,
                              input logic [31:0] tgt, input logic erv, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] epc);
    add_x(nm, ir, rdy, redir, tgt, erv, ea, eiv, epc, 1'b0, 32'h0);
  endfunction

  function automatic void add_rst(input string nm, input int l);
    vec_t v;
    fl = l;
    v.name = nm; v.rst = 1'b1; v.ir = 1'b1; v.rdy = 1'b1; v.redir = 1'b0; v.tgt = 32'h0; v.lat = l;
    v.full = 1'b0; v.e_rv = 1'b0; v.e_addr = 32'h0; v.e_iv = 1'b0; v.e_pc = 32'h0; v.e_fv = 1'b0; v.e_fa = 32'h0;
    vt.push_back(v);
  endfunction

  task automatic set_in(input logic rst, input logic ir, input logic rdy, input logic redir, input logic [31:0] tgt);
    reset = rst; inst_ready = ir; imem_req_ready = rdy; redirect_valid = redir; redirect_target = tgt;
  endtask

  // Advance one clock; memory returns responses in order, one per accepted request.
  task automatic tick();
    logic        acc, fired, was_rst;
    logic [31:0] a;
    mreq_t       r;
    acc = imem_req_valid && imem_req_ready;
    fired = imem_rsp_valid;
    was_rst = reset;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      mq.delete();
    end else begin
      if (fired && mq.size() > 0) mq.delete(0);
      if (acc) begin
        r.addr = a;
        r.due = cyc + lat - 1;
        mq.push_back(r);
      end
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;
    end
  endtask

  task automatic check_row(input int idx, input vec_t x);
    logic bad;
    n_vec++;
    bad = (imem_req_valid !== x.e_rv) || (x.e_rv && imem_req_addr !== x.e_addr);
    if (x.full) begin
      bad = bad || (inst_valid !== x.e_iv) ||
            (x.e_iv && (inst_pc !== x.e_pc || inst_data !== mem_word(x.e_pc))) ||
            (fault_valid !== x.e_fv) || (fault_addr !== x.e_fa);
    end
    if (bad) begin
      n_bad++;
      $display("FAIL %s vec %0d: got req_valid=%b addr=%h inst_valid=%b pc=%h data=%h fault=%b/%h; need req_valid=%b addr=%h inst_valid=%b pc=%h data=%h fault=%b/%h",
               x.name, idx, imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, fault_valid, fault_addr,
               x.e_rv, x.e_addr, x.e_iv, x.e_pc, mem_word(x.e_pc), x.e_fv, x.e_fa);
    end
  endtask

  initial begin
    int exp_pc;
    int got;
    reset = 1'b1; inst_ready = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    cyc = 0; lat = 1; n_vec = 0; n_bad = 0; fl = 1;

    // Streaming fetch, latency 1.
    add_rst("rst", 1); add_rst("rst", 1);
    add("stream", 1, 1, 0, 0, 1, 32'h00, 0, 0);
    add("stream", 1, 1, 0, 0, 1, 32'h04, 0, 0);
    add("stream", 1, 1, 0, 0, 1, 32'h08, 1, 32'h00);
    add("stream", 1, 1, 0, 0, 1, 32'h0C, 1, 32'h04);
    add("stream", 1, 1, 0, 0, 1, 32'h10, 1, 32'h08);
    add("stream", 1, 1, 0, 0, 1, 32'h14, 1, 32'h0C);
    // Decode stall: credit closes at 4 outstanding+queued, order kept on release.
    add_rst("rst", 1); add_rst("rst", 1);
    add("stall", 0, 1, 0, 0, 1, 32'h00, 0, 0);
    add("stall", 0, 1, 0, 0, 1, 32'h04, 0, 0);
    add("stall", 0, 1, 0, 0, 1, 32'h08, 1, 32'h00);
    add("stall", 0, 1, 0, 0, 1, 32'h0C, 1, 32'h00);
    for (int k = 0; k < 6; k++) add("stall", 0, 1, 0, 0, 0, 32'h0, 1, 32'h00);
    add("release", 1, 1, 0, 0, 0, 32'h0, 1, 32'h00);
    add("release", 1, 1, 0, 0, 1, 32'h10, 1, 32'h04);
    add("release", 1, 1, 0, 0, 1, 32'h14, 1, 32'h08);
    add("release", 1, 1, 0, 0, 1, 32'h18, 1, 32'h0C);
    add("release", 1, 1, 0, 0, 1, 32'h1C, 1, 32'h10);
    // Redirect with 3 in flight, latency 3.
    add_rst("rst", 3); add_rst("rst", 3);
    add("drain", 1, 1, 0, 0, 1, 32'h00, 0, 0);
    add("drain", 1, 1, 0, 0, 1, 32'h04, 0, 0);
    add("drain", 1, 1, 1, 32'h100, 1, 32'h08, 0, 0);
    for (int k = 0; k < 3; k++) add("drain", 1, 1, 0, 0, 0, 32'h0, 0, 0);
    add("drain", 1, 1, 0, 0, 1, 32'h100, 0, 0);
    add("drain", 1, 1, 0, 0, 1, 32'h104, 0, 0);
    add("drain", 1, 1, 0, 0, 1, 32'h108, 0, 0);
    add("drain", 1, 1, 0, 0, 1, 32'h10C, 0, 0);
    add("drain", 1, 1, 0, 0, 0, 32'h0, 1, 32'h100);
    add("drain", 1, 1, 0, 0, 1, 32'h110, 1, 32'h104);
    add("drain", 1, 1, 0, 0, 1, 32'h114, 1, 32'h108);
    add("drain", 1, 1, 0, 0, 1, 32'h118, 1, 32'h10C);
    // Redirect coinciding with a response and a request accept.
    add_rst("rst", 1); add_rst("rst", 1);
    add("redir_same", 1, 1, 0, 0, 1, 32'h00, 0, 0);
    add("redir_same", 1, 1, 0, 0, 1, 32'h04, 0, 0);
    add("redir_same", 1, 1, 1, 32'h200, 1, 32'h08, 1, 32'h00);
    add("redir_same", 1, 1, 0, 0, 0, 32'h0, 0, 0);
    add("redir_same", 1, 1, 0, 0, 1, 32'h200, 0, 0);
    add("redir_same", 1, 1, 0, 0, 1, 32'h204, 0, 0);
    add("redir_same", 1, 1, 0, 0, 1, 32'h208, 1, 32'h200);
    add("redir_same", 1, 1, 0, 0, 1, 32'h20C, 1, 32'h204);
    // Misaligned redirect with nothing in flight.
    add_rst("rst", 1); add_rst("rst", 1);
    add("misalign", 1, 0, 0, 0, 1, 32'h00, 0, 0);
    add("misalign", 1, 0, 1, 32'h102, 1, 32'h00, 0, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    add_x("misalign", 1, 1, 0, 0, 0, 32'h0, 0, 0, 1, 32'h102);
    add_x("misalign", 1, 1, 1, 32'h200, 0, 32'h0, 0, 0, 1, 32'h102);
    add_x("misalign", 1, 1, 0, 0, 0, 32'h0, 0, 0, 1, 32'h102);
`else
    add("misalign", 1, 1, 0, 0, 1, 32'h100, 0, 0);
    add("misalign", 1, 1, 0, 0, 1, 32'h104, 0, 0);
    add("misalign", 1, 0, 0, 0, 1, 32'h108, 1, 32'h100);
`endif
    // Reset while draining with 2 in flight.
    add_rst("rst", 4); add_rst("rst", 4);
    add("rst_drain", 1, 1, 0, 0, 1, 32'h00, 0, 0);
    add("rst_drain", 1, 1, 0, 0, 1, 32'h04, 0, 0);
    add("rst_drain", 1, 0, 1, 32'h300, 1, 32'h08, 0, 0);
    add("rst_drain", 1, 0, 0, 0, 0, 32'h0, 0, 0);
    add_rst("rst_drain", 4);
    add("rst_drain", 1, 0, 0, 0, 1, 32'h00, 0, 0);
    add("rst_drain", 1, 0, 0, 0, 1, 32'h00, 0, 0);

    foreach (vt[i]) begin
      set_in(vt[i].rst, vt[i].ir, vt[i].rdy, vt[i].redir, vt[i].tgt);
      lat = vt[i].lat;
      @(negedge clk);
      check_row(i, vt[i]);
      tick();
    end

    // Random back-pressure on both sides: delivered stream must be gap-free and in order.
    lat = 2;
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      tick();
    end
    exp_pc = 0;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      set_in(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        n_vec++;
        if (inst_pc !== 32'(exp_pc) || inst_data !== mem_word(32'(exp_pc))) begin
          n_bad++;
          $display("FAIL random_stream: got pc=%h data=%h; need pc=%h data=%h",
                   inst_pc, inst_data, 32'(exp_pc), mem_word(32'(exp_pc)));
        end
        exp_pc += 4;
        got++;
      end
      tick();
    end
    n_vec++;
    if (got < 20) begin
      n_bad++;
      $display("FAIL stream_budget: got %0d deliveries; need at least 20", got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/PC width.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning PC loaded on reset.
REQ-003 SHALL have parameter DEPTH, default 4, meaning fetch-queue entries and max in-flight credit; power of 2, minimum 2.
REQ-004 SHALL have ports: clk in 1, clock; reset in 1, reset, synchronous, active-high.
REQ-005 SHALL have ports: imem_req_valid out 1, request; imem_req_ready in 1, memory accepts; imem_req_addr out XLEN, fetch address.
REQ-006 SHALL have ports: imem_rsp_valid in 1, response; imem_rsp_data in 32, instruction word.
REQ-007 SHALL have ports: redirect_valid in 1, taken branch/jal/jalr; redirect_target in XLEN, new PC.
REQ-008 SHALL have ports: inst_valid out 1; inst_ready in 1; inst_data out 32; inst_pc out XLEN (decode-side handshake).
REQ-009 SHALL have ports: fault_valid out 1, misaligned redirect; fault_addr out XLEN, offending target.

Function
REQ-010 SHALL hold fetch PC register pc; request accepted when imem_req_valid && imem_req_ready; on accept pc <= pc + 4, modulo 2^XLEN.
REQ-011 SHALL drive imem_req_addr = pc; imem_req_valid = (state==RUN) && (inflight + occupancy < DEPTH).
REQ-012 SHALL assume memory responses return in order, latency >= 1 cycle, exactly one per accepted request.
REQ-013 SHALL push {request PC, imem_rsp_data} into queue on imem_rsp_valid when not dropping; credit rule guarantees no overflow.
REQ-014 SHALL present queue head on inst_valid/inst_data/inst_pc; pop when inst_valid && inst_ready; inst_data/inst_pc stable while inst_valid && !inst_ready.
REQ-015 SHALL implement FSM states RUN, DRAIN, HALT.
REQ-016 SHALL, on redirect_valid in any state except HALT: pc <= redirect_target, queue flushed, drop count <= inflight (minus response arriving same cycle), next state DRAIN if drop count nonzero else RUN.
REQ-017 SHALL, in DRAIN, issue no requests, discard each response and decrement drop count; go to RUN the cycle drop count reaches 0.
REQ-018 SHALL discard a response arriving in the same cycle as redirect_valid.
REQ-019 SHALL give redirect priority over a simultaneous request accept; the accepted request counts as in-flight and is dropped.
REQ-020 SHALL allow simultaneous push and pop on a full or empty queue without loss; pop of the sole entry with same-cycle push keeps inst_valid high.
REQ-021 SHALL keep inst_valid low in the cycle after redirect (flush visible immediately).

Reset
REQ-022 SHALL on reset: pc=RESET_VEC, state=RUN, queue empty, inflight=0, drop count=0, inst_valid=0, imem_req_valid=0 during reset, fault_valid=0, fault_addr=0.
REQ-023 SHALL on reset mid-operation drop all in-flight responses by ignoring imem_rsp_valid while reset is high; memory subsystem is reset concurrently.

Configuration
REQ-024 SHALL with macro FETCH_MISALIGN_CHK_EN defined: redirect with target[1:0]!=0 sets fault_valid=1, fault_addr=target, flushes queue, enters HALT (no requests) until reset.
REQ-025 SHALL without FETCH_MISALIGN_CHK_EN: target[1:0] ignored (pc <= {target[XLEN-1:2],2'b00}), fault_valid and fault_addr tied 0.

Structure
REQ-026 SHALL place XLEN default, INST_W=32, INST_BYTES=4 and state enum in shared package fetch_pkg.
REQ-027 SHALL implement queue as sub-module fetch_fifo (parametrised width, DEPTH, flush input).

Verification
REQ-028 Reset, imem_req_ready=1, 1-cycle latency, inst_ready=1 -> inst_pc sequence 0,4,8,12 with matching inst_data.
REQ-029 inst_ready=0 for 10 cycles -> imem_req_valid drops after 4 outstanding+queued; no data lost; order 0..12 preserved on release.
REQ-030 Redirect to 0x100 with 3 in flight, latency 3 -> 3 responses dropped, next inst_pc=0x100, no stale word delivered.
REQ-031 Redirect same cycle as response and request accept -> both discarded, fetch resumes at target.
REQ-032 With FETCH_MISALIGN_CHK_EN, redirect to 0x102 -> fault_valid=1, fault_addr=0x102, no further requests; without macro -> fetch at 0x100.
REQ-033 Reset asserted in DRAIN with 2 in flight -> next cycle after release pc=RESET_VEC, inst_valid=0, queue empty.
